// File: rtl/linterp_mc_if.sv
// Stream bundle for the linear-interpolation upsampler: input vector port, output vector port and phase.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carried with their valids; the interpolator side is the slave modport.
interface linterp_mc_if #(
    parameter int DW     = 16,
    parameter int INTERP = 32,
    parameter int NCH    = 1
);
    localparam int IW = $clog2(INTERP);

    logic                  in_valid;
    logic                  in_ready;
    logic [NCH*2*DW-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [NCH*2*DW-1:0]   out_data;
    logic [IW-1:0]         out_phase;

    // Environment side: produces input vectors, consumes output vectors.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_phase
    );

    // Interpolator side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_phase
    );
endinterface

// File: rtl/linterp_mc.sv
// Linear-interpolation upsampler: each input vector x[n] yields INTERP vectors stepping from x[n-1] toward x[n].
// Latency: input accepted in WAIT at cycle t gives phase 0 at t+1; sustained one output vector per clock.
// Backpressure: out_ready low freezes data/phase; in_ready follows out_ready combinationally on the last phase.
module linterp_mc #(
    parameter int DW     = 16,
    parameter int INTERP = 32,
    parameter int NCH    = 1,
    parameter int ROUND  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           mode,
    linterp_mc_if.slave    io
);
    localparam int IW = $clog2(INTERP);
    localparam int BW = NCH * 2 * DW;
    // Working width: DW+1 bits for the difference, IW bits for the phase, one guard bit for rounding.
    localparam int W  = DW + IW + 2;
    localparam logic [IW-1:0]        K_LAST  = IW'(INTERP - 1);
    localparam logic signed [W-1:0]  RND_ADD = (ROUND != 0) ? W'(1 << (IW - 1)) : W'(0);

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,   // no history yet
        ST_WAIT  = 2'd1,   // prev held, waiting for the next vector
        ST_RUN   = 2'd2    // emitting INTERP phases between prev and cur
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    k_q, k_d;
    logic [BW-1:0]    prev_q, prev_d;
    logic [BW-1:0]    cur_q, cur_d;
    logic             mode_q, mode_d;

    logic             out_vld;
    logic             in_rdy;
    logic             in_fire;
    logic             out_fire;
    logic [BW-1:0]    y_dat;
    logic signed [W-1:0] k_s;

    // Handshake: output is valid throughout RUN; a new vector can enter whenever we are not
    // emitting, or on the very cycle the last phase leaves so the stream has no bubble.
    assign out_vld  = (state_q == ST_RUN);
    assign in_rdy   = !flush && ((state_q != ST_RUN) || ((k_q == K_LAST) && io.out_ready));
    assign in_fire  = io.in_valid && in_rdy;
    assign out_fire = out_vld && io.out_ready;

    assign io.in_ready  = in_rdy;
    assign io.out_valid = out_vld;
    assign io.out_phase = k_q;
    assign io.out_data  = out_vld ? y_dat : '0;

    // Phase as a non-negative signed operand for the per-component multiply.
    assign k_s = {{(W - IW){1'b0}}, k_q};

    // Every real and imaginary component is an independent interpolator sharing the phase.
    for (genvar j = 0; j < 2 * NCH; j++) begin : g_comp
        logic signed [W-1:0] a_s;
        logic signed [W-1:0] b_s;
        logic signed [W-1:0] p_s;
        logic signed [W-1:0] y_s;
        logic [W-DW-1:0]     y_unused;

        // y = prev + ((cur - prev) * k + rounding) >>> IW, at full width so extremes cannot wrap.
        always_comb begin
            a_s = {{(W - DW){prev_q[j*DW + DW - 1]}}, prev_q[j*DW +: DW]};
            b_s = {{(W - DW){cur_q[j*DW + DW - 1]}},  cur_q[j*DW +: DW]};
            p_s = (b_s - a_s) * k_s;
            y_s = a_s + ((p_s + RND_ADD) >>> IW);
        end

        // The result lies between prev and cur, so the upper bits are pure sign extension.
        assign y_dat[j*DW +: DW] = mode_q ? prev_q[j*DW +: DW] : y_s[DW-1:0];
        assign y_unused          = y_s[W-1:DW];
    end

    // Next-state logic: flush wins over everything; a run rolls straight into the next one
    // when a vector is waiting on the final phase.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        mode_d  = mode_q;
        if (flush) begin
            state_d = ST_PRIME;
            k_d     = '0;
        end else begin
            case (state_q)
                ST_PRIME: begin
                    if (in_fire) begin
                        prev_d  = io.in_data;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (in_fire) begin
                        cur_d   = io.in_data;
                        k_d     = '0;
                        mode_d  = mode;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (out_fire) begin
                        if (k_q != K_LAST) begin
                            k_d = k_q + IW'(1);
                        end else begin
                            prev_d = cur_q;
                            k_d    = '0;
                            if (in_fire) begin
                                cur_d  = io.in_data;
                                mode_d = mode;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_PRIME;
                    k_d     = '0;
                end
            endcase
        end
    end

    // State, phase, sample history and the per-run mode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PRIME;
            k_q     <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            mode_q  <= mode_d;
        end
    end
endmodule

// File: tb/tb_linterp_mc.sv
// Directed bench for linterp_mc at DW=16, INTERP=4, NCH=1; a second ROUND=0 copy shares the stimulus.
// Latency: checks phase 0 one cycle after the second vector is accepted.
// Backpressure: exercised with random out_ready stalls and a continuous stream.
module tb_linterp_mc;
    localparam int DW     = 16;
    localparam int INTERP = 4;
    localparam int NCH    = 1;

    typedef int v4_t [4];

    logic clk;
    logic rst_n;
    logic flush;
    logic mode;

    int checks;
    int errors;

    linterp_mc_if #(.DW(DW), .INTERP(INTERP), .NCH(NCH)) bus  ();
    linterp_mc_if #(.DW(DW), .INTERP(INTERP), .NCH(NCH)) bus0 ();

    assign bus0.in_valid  = bus.in_valid;
    assign bus0.in_data   = bus.in_data;
    assign bus0.out_ready = bus.out_ready;

    linterp_mc #(.DW(DW), .INTERP(INTERP), .NCH(NCH), .ROUND(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .mode  (mode),
        .io    (bus.slave)
    );

    linterp_mc #(.DW(DW), .INTERP(INTERP), .NCH(NCH), .ROUND(0)) u_dut_trunc (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .mode  (mode),
        .io    (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int re_of(input logic [31:0] d);
        return int'($signed(d[15:0]));
    endfunction

    function automatic int im_of(input logic [31:0] d);
        return int'($signed(d[31:16]));
    endfunction

    function automatic logic [31:0] pack(input int r, input int i);
        return {16'(i), 16'(r)};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; one-cycle flush pulse.
    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Called just after a rising edge; offers one vector and returns just after it is taken.
    task automatic push(input logic [31:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("push_rdy", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Four phases with out_ready high, then the return to WAIT.
    task automatic expect4(input string tag, input v4_t er, input v4_t ei,
                           input bit chk_t, input v4_t et);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_vld"}, int'(bus.out_valid), 1);
            check({tag, "_ph"},  int'(bus.out_phase), k);
            check({tag, "_re"},  re_of(bus.out_data), er[k]);
            check({tag, "_im"},  im_of(bus.out_data), ei[k]);
            if (chk_t) check({tag, "_trunc"}, re_of(bus0.out_data), et[k]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({tag, "_end"}, int'(bus.out_valid), 0);
        @(posedge clk); #1;
    endtask

    // Re-prime, feed a then b with mode m for b's run, flip mode mid-run to prove it is latched.
    task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic m, input v4_t er, input v4_t ei,
                            input bit chk_t, input v4_t et);
        do_flush();
        push(a);
        mode = m;
        push(b);
        mode = ~m;
        expect4(tag, er, ei, chk_t, et);
    endtask

    initial begin
        int x;
        int nout;
        int nrdy;
        int guard;
        bit fire;
        bit seen;

        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        mode          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_vld",  int'(bus.out_valid), 0);
        check("rst_dat",  int'(bus.out_data), 0);
        check("rst_ph",   int'(bus.out_phase), 0);
        check("rst_rdy",  int'(bus.in_ready), 1);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic linear ramp, halving/imag-lane case, rounding vs truncation, extremes, hold mode
        run_pair("lin",  pack(0, 0), pack(400, 0), 1'b0,
                 '{0, 100, 200, 300}, '{0, 0, 0, 0}, 1'b1, '{0, 100, 200, 300});
        run_pair("neg",  pack(100, 0), pack(-100, -8), 1'b0,
                 '{100, 50, 0, -50}, '{0, -2, -4, -6}, 1'b0, '{0, 0, 0, 0});
        run_pair("rnd",  pack(0, 0), pack(3, 0), 1'b0,
                 '{0, 1, 2, 2}, '{0, 0, 0, 0}, 1'b1, '{0, 0, 1, 2});
        run_pair("ext",  pack(-32768, 32767), pack(32767, -32768), 1'b0,
                 '{-32768, -16384, 0, 16383}, '{32767, 16383, 0, -16384}, 1'b0, '{0, 0, 0, 0});
        run_pair("hold", pack(10, 0), pack(50, 0), 1'b1,
                 '{10, 10, 10, 10}, '{0, 0, 0, 0}, 1'b1, '{10, 10, 10, 10});
        mode = 1'b0;

        // Continuous stream: one output per clock, in_ready high on one clock in four
        do_flush();
        x = 0; nout = 0; nrdy = 0; guard = 0; seen = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = pack(0, 0);
        while (nout < 16 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (seen || bus.out_valid) begin
                seen = 1'b1;
                check("stream_vld", int'(bus.out_valid), 1);
                check("stream_re",  re_of(bus.out_data), nout);
                check("stream_im",  im_of(bus.out_data), -nout);
                check("stream_ph",  int'(bus.out_phase), nout % 4);
                if (bus.in_ready) nrdy++;
                nout++;
            end
            fire = bus.in_ready;
            @(posedge clk); #1;
            if (fire) begin
                x += 4;
                bus.in_data = pack(x, -x);
            end
        end
        bus.in_valid = 1'b0;
        check("stream_count", nout, 16);
        check("stream_rdy_cnt", nrdy, 4);

        // Random output stalls: the pending output must hold until taken
        do_flush();
        x = 0; nout = 0; guard = 0; seen = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = pack(0, 0);
        while (nout < 12 && guard < 300) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
            if (seen || bus.out_valid) begin
                seen = 1'b1;
                check("stall_vld", int'(bus.out_valid), 1);
                check("stall_re",  re_of(bus.out_data), 2 * nout);
                check("stall_im",  im_of(bus.out_data), -2 * nout);
                check("stall_ph",  int'(bus.out_phase), nout % 4);
                if (bus.out_ready) nout++;
            end
            fire = bus.in_ready;
            @(posedge clk); #1;
            if (fire) begin
                x += 8;
                bus.in_data = pack(x, -x);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stall_count", nout, 12);

        // Flush mid-run with a competing input: input refused, run dropped, re-prime needed
        do_flush();
        push(pack(0, 0));
        push(pack(400, 0));
        @(negedge clk);
        check("fl_ph0", re_of(bus.out_data), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("fl_ph1", re_of(bus.out_data), 100);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = pack(999, 999);
        #1;
        check("fl_rdy", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("fl_vld", int'(bus.out_valid), 0);
        check("fl_k",   int'(bus.out_phase), 0);
        @(posedge clk); #1;
        push(pack(20, 0));
        @(negedge clk);
        check("fl_prime", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        push(pack(60, 0));
        expect4("fl_run", '{20, 30, 40, 50}, '{0, 0, 0, 0}, 1'b0, '{0, 0, 0, 0});

        // Asynchronous reset mid-run, asserted and released away from the clock edge
        do_flush();
        push(pack(0, 0));
        push(pack(400, 0));
        @(negedge clk);
        check("ar_ph0", int'(bus.out_valid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_vld", int'(bus.out_valid), 0);
        check("ar_dat", int'(bus.out_data), 0);
        check("ar_ph",  int'(bus.out_phase), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        push(pack(8, 0));
        push(pack(16, 0));
        expect4("ar_run", '{8, 10, 12, 14}, '{0, 0, 0, 0}, 1'b0, '{0, 0, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
